hwag_sync_ctrl: RTL

HWAG_SYNC_CTRL -- requirements
Module: hwag_sync_ctrl

---
 rtl/hwag_pkg.sv | 22 ++
 rtl/hwag_cam_sync.sv | 46 ++++
 rtl/hwag_sync_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hwag_pkg.sv
// Shared types and default sizing for the crank/cam synchronisation controller.
package hwag_pkg;

    localparam int TEETH_DEF    = 58;
    localparam int PERIOD_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEEK_GAP = 3'd1,
        ST_VERIFY   = 3'd2,
        ST_SYNCED   = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_TOOTH = 2'd1,
        ERR_CAM   = 2'd2,
        ERR_STALL = 2'd3
    } err_e;

endpackage

// File: rtl/hwag_cam_sync.sv
// Cam level synchroniser plus the cam level captured at the previous accepted gap.
module hwag_cam_sync
    import hwag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cam,
    input  logic clr,
    input  logic gap_acc,
    output logic cam_s,
    output logic last_cam,
    output logic have_last
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic last_q, last_d;
    logic have_q, have_d;

    always_comb begin
        meta_d = cam;
        sync_d = meta_q;
        last_d = gap_acc ? sync_q : last_q;
        // History is dropped whenever crank lock is lost, so phase must be re-proven.
        have_d = clr ? 1'b0 : (gap_acc ? 1'b1 : have_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
            have_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            last_q <= last_d;
            have_q <= have_d;
        end
    end

    assign cam_s     = sync_q;
    assign last_cam  = last_q;
    assign have_last = have_q;

endmodule

// File: rtl/hwag_sync_ctrl.sv
// Crank wheel gap search / tooth counting FSM with cam phase tracking and error reporting.
module hwag_sync_ctrl
    import hwag_pkg::*;
#(
    parameter int TEETH    = TEETH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                tooth_evt,
    input  logic [PERIOD_W-1:0] tooth_period,
    input  logic                cam,
    input  logic [PERIOD_W-1:0] stall_limit,
    output logic                sync,
    output logic                phase,
    output logic                phase_valid,
    output logic [6:0]          tooth_num,
    output logic                rev_evt,
    output logic                core_run,
    output logic                err_evt,
    output logic [1:0]          err_code,
    output logic [7:0]          err_cnt,
    output logic [2:0]          state
);

    localparam logic [6:0] LAST_TOOTH = 7'(TEETH - 1);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] prev_period_q, prev_period_d;
    logic [PERIOD_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                prev_valid_q, prev_valid_d;
    logic [6:0]          tooth_num_q, tooth_num_d;
    logic                phase_q, phase_d;
    logic                phase_valid_q, phase_valid_d;
    logic                rev_evt_q, rev_evt_d;
    logic                core_run_q, core_run_d;
    logic                err_evt_q, err_evt_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic gap, accept, stall_hit, in_count, cam_s, last_cam, have_last;
    logic err_now;
    err_e err_sel;

    // Widened compare so 2*prev_period cannot overflow.
    assign gap       = tooth_evt && prev_valid_q &&
                       ({1'b0, tooth_period} >= {prev_period_q, 1'b0});
    assign in_count  = (state_q == ST_VERIFY) || (state_q == ST_SYNCED);
    assign accept    = en && in_count && gap && (tooth_num_q == LAST_TOOTH);
    assign stall_hit = en && !tooth_evt && (state_q != ST_IDLE) &&
                       (stall_cnt_q == stall_limit);

    hwag_cam_sync u_cam_sync (
        .clk       (clk),
        .rst       (rst),
        .cam       (cam),
        .clr       ((state_q == ST_IDLE) || (state_q == ST_FAULT)),
        .gap_acc   (accept),
        .cam_s     (cam_s),
        .last_cam  (last_cam),
        .have_last (have_last)
    );

    always_comb begin
        state_d       = state_q;
        prev_period_d = tooth_evt ? tooth_period : prev_period_q;
        prev_valid_d  = prev_valid_q | tooth_evt;
        tooth_num_d   = tooth_num_q;
        stall_cnt_d   = tooth_evt ? '0 :
                        (&stall_cnt_q ? stall_cnt_q : stall_cnt_q + 1'b1);
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        err_now       = 1'b0;
        err_sel       = ERR_NONE;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    prev_valid_d  = 1'b0;
                    tooth_num_d   = '0;
                    phase_valid_d = 1'b0;
                    state_d       = ST_SEEK_GAP;
                end
                ST_SEEK_GAP: begin
                    if (gap) begin
                        state_d     = ST_VERIFY;
                        tooth_num_d = '0;
                    end
                end
                ST_VERIFY, ST_SYNCED: begin
                    if (gap) begin
                        if (tooth_num_q == LAST_TOOTH) begin
                            state_d     = ST_SYNCED;
                            tooth_num_d = '0;
                        end else begin
                            err_now = 1'b1;
                            err_sel = ERR_TOOTH;
                        end
                    end else if (tooth_evt) begin
                        if (tooth_num_q == LAST_TOOTH) begin
                            err_now = 1'b1;
                            err_sel = ERR_TOOTH;
                        end else begin
                            tooth_num_d = tooth_num_q + 7'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    phase_valid_d = 1'b0;
                    state_d       = ST_SEEK_GAP;
                end
                default: state_d = ST_IDLE;
            endcase

            if (accept) begin
                phase_d = ~cam_s;
                if (have_last) begin
                    if (cam_s == last_cam) begin
                        err_now       = 1'b1;
                        err_sel       = ERR_CAM;
                        phase_valid_d = 1'b0;
                    end else begin
                        phase_valid_d = 1'b1;
                    end
                end
            end

            if (stall_hit) begin
                err_now = 1'b1;
                err_sel = ERR_STALL;
            end

            // Cam disagreement only invalidates phase; crank lock survives it.
            if (err_now && (err_sel != ERR_CAM)) begin
                state_d       = ST_FAULT;
                tooth_num_d   = '0;
                phase_valid_d = 1'b0;
            end
        end

        rev_evt_d  = accept;
        core_run_d = (state_q == ST_SYNCED);
        err_evt_d  = err_now;
        err_code_d = err_now ? err_sel : err_code_q;
        err_cnt_d  = (err_now && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            prev_period_q <= '0;
            stall_cnt_q   <= '0;
            prev_valid_q  <= 1'b0;
            tooth_num_q   <= '0;
            phase_q       <= 1'b0;
            phase_valid_q <= 1'b0;
            rev_evt_q     <= 1'b0;
            core_run_q    <= 1'b0;
            err_evt_q     <= 1'b0;
            err_code_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            prev_period_q <= prev_period_d;
            stall_cnt_q   <= stall_cnt_d;
            prev_valid_q  <= prev_valid_d;
            tooth_num_q   <= tooth_num_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            rev_evt_q     <= rev_evt_d;
            core_run_q    <= core_run_d;
            err_evt_q     <= err_evt_d;
            err_code_q    <= err_code_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign sync        = (state_q == ST_SYNCED);
    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign tooth_num   = tooth_num_q;
    assign rev_evt     = rev_evt_q;
    assign core_run    = core_run_q;
    assign err_evt     = err_evt_q;
    assign err_code    = err_code_q;
    assign err_cnt     = err_cnt_q;
    assign state       = state_q;

endmodule
